// File: rtl/assoc_cache.sv
// -----------------------------------------------------------------------------
// assoc_cache
//   N-way set-associative, write-through, write-allocate cache with an
//   integrated miss FSM and true-age LRU replacement. Sits between the
//   pipeline memory stage (req/resp) and a multi-cycle main memory (mem_*).
//
//   Optional feature macro: CACHE_PERF_EN adds the hit_cnt/miss_cnt outputs.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = write, 0 = read
//   req_addr          byte address (byte-offset bits ignored)
//   req_wdata         write data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        read data (0 unless a read completes)
//   miss              one-cycle pulse on a lookup miss
//   mem_req/we/addr/wdata  memory request, held until mem_ack
//   mem_ack           memory accepts the request
//   mem_rvalid/rdata  fill beats, WORDS beats in word order
//   hit_cnt, miss_cnt saturating 32-bit counters (CACHE_PERF_EN only)
// -----------------------------------------------------------------------------
module assoc_cache #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int WAYS   = 2,
   parameter int SETS   = 64,
   parameter int WORDS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              miss,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_PERF_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   localparam int BOFF_W  = $clog2(DATA_W / 8);
   localparam int WOFF_W  = $clog2(WORDS);
   localparam int INDEX_W = $clog2(SETS);
   localparam int TAG_W   = ADDR_W - INDEX_W - WOFF_W - BOFF_W;
   localparam int AGE_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

   // Masks clear the byte offset (word address) or the whole block offset
   // (fill base address); expressed as masks so a zero-width offset still works.
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((1 << BOFF_W) - 1);
   localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'((1 << (BOFF_W + WOFF_W)) - 1);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, FILL_REQ, FILL, WR_MEM, DONE
   } state_t;

   // Storage
   logic [DATA_W-1:0] data_q  [WAYS][SETS][WORDS];
   logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
   logic [SETS-1:0]   valid_q [WAYS];
   logic [AGE_W-1:0]  age_q   [SETS][WAYS];

   // Control state
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [AGE_W-1:0]    victim_q;
   logic [WOFF_W-1:0]   cnt_q;

   // Address fields of the registered request
   logic [INDEX_W-1:0]  idx;
   logic [TAG_W-1:0]    tag;
   logic [WOFF_W-1:0]   word;

   assign idx  = addr_q[BOFF_W + WOFF_W +: INDEX_W];
   assign tag  = addr_q[ADDR_W-1 -: TAG_W];
   assign word = addr_q[BOFF_W +: WOFF_W];

   // Lookup and victim selection
   logic             hit;
   logic [AGE_W-1:0] hit_way;
   logic [AGE_W-1:0] victim_way;
   logic             inv_found;

   // NOTE: every signal assigned in always_comb gets a default at the top so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      hit        = 1'b0;
      hit_way    = '0;
      victim_way = '0;
      inv_found  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
            hit     = 1'b1;
            hit_way = AGE_W'(w);
         end
      end
      // Lowest-index invalid way first, otherwise the oldest way.
      for (int w = 0; w < WAYS; w++) begin
         if (!inv_found && !valid_q[w][idx]) begin
            inv_found  = 1'b1;
            victim_way = AGE_W'(w);
         end
      end
      if (!inv_found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[idx][w] == AGE_W'(WAYS - 1)) victim_way = AGE_W'(w);
         end
      end
   end

   logic fill_beat, fill_last;
   assign fill_beat = (state_q == FILL) && mem_rvalid;
   assign fill_last = fill_beat && (cnt_q == WOFF_W'(WORDS - 1));

   // Next state and outputs
   logic             lru_upd;
   logic [AGE_W-1:0] lru_way;

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      miss       = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      lru_upd    = 1'b0;
      lru_way    = hit_way;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = LOOKUP;
         end
         LOOKUP: begin
            if (hit) begin
               lru_upd = 1'b1;
               if (we_q) begin
                  state_d = WR_MEM;
               end else begin
                  resp_valid = 1'b1;
                  resp_rdata = data_q[hit_way][idx][word];
                  state_d    = IDLE;
               end
            end else begin
               miss    = 1'b1;
               state_d = FILL_REQ;
            end
         end
         FILL_REQ: begin
            mem_req  = 1'b1;
            mem_addr = addr_q & BLK_MASK;
            if (mem_ack) state_d = FILL;
         end
         FILL: begin
            if (fill_last) begin
               lru_upd = 1'b1;
               lru_way = victim_q;
               state_d = LOOKUP;
            end
         end
         WR_MEM: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q & WORD_MASK;
            mem_wdata = wdata_q;
            if (mem_ack) state_d = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers and valid bits
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         victim_q <= '0;
         cnt_q    <= '0;
         for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
         end
         if (state_q == LOOKUP && !hit) begin
            victim_q                <= victim_way;
            valid_q[victim_way][idx] <= 1'b0;
         end
         if (fill_beat) cnt_q <= cnt_q + 1'b1;  // wraps to 0 after the last beat
         if (fill_last) valid_q[victim_q][idx] <= 1'b1;
      end
   end

   // Data and tag arrays
   // NOTE: data and tag storage are not reset; the valid bits alone make stale
   // contents unobservable. Writes are still gated by rst so a reset cycle
   // cannot deposit a fill beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (state_q == LOOKUP && hit && we_q) data_q[hit_way][idx][word] <= wdata_q;
         if (fill_beat) data_q[victim_q][idx][cnt_q] <= mem_rdata;
         if (fill_last) tag_q[victim_q][idx] <= tag;
      end
   end

   // LRU ages: the touched way becomes youngest, younger ways age by one.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age_q[s][w] <= AGE_W'(w);
      end else if (lru_upd) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[idx][w] < age_q[idx][lru_way]) age_q[idx][w] <= age_q[idx][w] + 1'b1;
         end
         age_q[idx][lru_way] <= '0;
      end
   end

`ifdef CACHE_PERF_EN
   // Saturating performance counters; the hit right after a fill is not a
   // genuine hit and is excluded via refill_q.
   logic        refill_q;
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         refill_q   <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (fill_last) refill_q <= 1'b1;
         else if (state_q == LOOKUP) refill_q <= 1'b0;
         if (state_q == LOOKUP && hit && !refill_q && hit_cnt_q != '1)
            hit_cnt_q <= hit_cnt_q + 1'b1;
         if (miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule
